// File: rtl/memory_bus_pkg.sv
// Shared types for the MemoryBus arbiter: FSM state, table entry, port-index width.
package memory_bus_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Wide enough for the largest legal port count (16).
  localparam int MAX_PORT_BITS = 4;

  typedef struct packed {
    logic [MAX_PORT_BITS-1:0] port;
    logic                     busy;
  } tbl_entry_t;

  function automatic int port_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import memory_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [port_bits(N)-1:0]   ptr,
  output logic                      any,
  output logic [port_bits(N)-1:0]   idx
);

  localparam int PB = port_bits(N);

  // Scan from the far end down so the nearest candidate to ptr is the last writer.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = PB'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// N-port MemoryBus arbiter: round-robin request merge with grant lock until
// downstream accept, and ID-table routing of responses back to the issuer.
// Optional macro MEMORY_BUS_ARBITER_ID_CHECK_EN adds per-ID busy tracking,
// stalls duplicate outstanding IDs and exposes a sticky id_error flag.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 24
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  // upstream ports
  input  logic [N_PORTS-1:0]                        sbus_ms_valid,
  output logic [N_PORTS-1:0]                        sbus_ms_taken,
  input  logic [N_PORTS-1:0][MASTER_ID_WIDTH-1:0]   sbus_ms_id,
  input  logic [N_PORTS-1:0][ADDRESS_WIDTH-1:0]     sbus_ms_address,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]        sbus_ms_data,
  output logic [N_PORTS-1:0]                        sbus_sm_valid,
  input  logic [N_PORTS-1:0]                        sbus_sm_taken,
  output logic [N_PORTS-1:0][MASTER_ID_WIDTH-1:0]   sbus_sm_id,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]        sbus_sm_data,
  // downstream port
  output logic                                      mbus_ms_valid,
  input  logic                                      mbus_ms_taken,
  output logic [MASTER_ID_WIDTH-1:0]                mbus_ms_id,
  output logic [ADDRESS_WIDTH-1:0]                  mbus_ms_address,
  output logic [DATA_WIDTH-1:0]                     mbus_ms_data,
  input  logic                                      mbus_sm_valid,
  output logic                                      mbus_sm_taken,
  input  logic [MASTER_ID_WIDTH-1:0]                mbus_sm_id,
  input  logic [DATA_WIDTH-1:0]                     mbus_sm_data
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
  ,
  output logic                                      id_error
`endif
);

  localparam int             PB    = port_bits(N_PORTS);
  localparam int             DEPTH = 1 << MASTER_ID_WIDTH;
  localparam logic [PB-1:0]  LAST  = PB'(N_PORTS - 1);

  arb_state_t      state, state_nxt;
  logic [PB-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PB-1:0]   grant, grant_nxt;
  logic [PB-1:0]   sel, pick_idx;
  logic            pick_any;
  logic            req_valid;
  logic            accept;
  logic [N_PORTS-1:0] eligible;
  logic [PB-1:0]   rsp_port;

  tbl_entry_t      tbl [DEPTH];

  function automatic logic [PB-1:0] next_port(input logic [PB-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Ports with a pending request that may compete; busy IDs sit out when checking is on.
  always_comb begin
    eligible = sbus_ms_valid;
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
    for (int i = 0; i < N_PORTS; i++) begin
      if (tbl[sbus_ms_id[i]].busy) eligible[i] = 1'b0;
    end
`endif
  end

  rr_pick #(.N(N_PORTS)) u_pick (
    .req (eligible),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration: pick in IDLE, hold the grant in LOCKED until the downstream accepts.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    sel        = pick_idx;
    req_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_valid = pick_any;
        if (pick_any) begin
          if (mbus_ms_taken) begin
            rr_ptr_nxt = next_port(pick_idx);
          end else begin
            grant_nxt = pick_idx;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        sel       = grant;
        req_valid = sbus_ms_valid[grant];
        if (!sbus_ms_valid[grant]) begin
          // Requester withdrew: release without moving the pointer.
          state_nxt = IDLE;
        end else if (mbus_ms_taken) begin
          rr_ptr_nxt = next_port(grant);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mbus_ms_valid = rst_n & req_valid;
  assign accept        = mbus_ms_valid & mbus_ms_taken;

  // Request pass-through from the selected port; only it sees msTaken.
  always_comb begin
    mbus_ms_id      = sbus_ms_id[sel];
    mbus_ms_address = sbus_ms_address[sel];
    mbus_ms_data    = sbus_ms_data[sel];
    sbus_ms_taken   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (PB'(i) == sel) sbus_ms_taken[i] = accept;
    end
  end

  assign rsp_port = PB'(tbl[mbus_sm_id].port);

  // Response routing: broadcast payload, steer valid/taken through the ID table.
  always_comb begin
    sbus_sm_valid = '0;
    mbus_sm_taken = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      sbus_sm_id[i]   = mbus_sm_id;
      sbus_sm_data[i] = mbus_sm_data;
      if (PB'(i) == rsp_port) begin
        sbus_sm_valid[i] = rst_n & mbus_sm_valid;
        mbus_sm_taken    = rst_n & sbus_sm_taken[i];
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
    end
  end

  // ID table: owner written on accept; busy cleared on response, then set on accept (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
      if (mbus_sm_valid && mbus_sm_taken) tbl[mbus_sm_id].busy <= 1'b0;
`endif
      if (accept) begin
        tbl[mbus_ms_id].port <= MAX_PORT_BITS'(sel);
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
        tbl[mbus_ms_id].busy <= 1'b1;
`endif
      end
    end
  end

`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
  // Sticky flag for a response handshake on an ID with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_error <= 1'b0;
    else if (mbus_sm_valid && mbus_sm_taken && !tbl[mbus_sm_id].busy) id_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter (N_PORTS=4): directed stimulus pushes
// expected request/response beats; a negedge monitor pops and compares.
module tb_memory_bus_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int AW = 32;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]         s_ms_valid, s_ms_taken;
  logic [N-1:0][IW-1:0] s_ms_id;
  logic [N-1:0][AW-1:0] s_ms_addr;
  logic [N-1:0][DW-1:0] s_ms_data;
  logic [N-1:0]         s_sm_valid, s_sm_taken;
  logic [N-1:0][IW-1:0] s_sm_id;
  logic [N-1:0][DW-1:0] s_sm_data;
  logic                 m_ms_valid, m_ms_taken;
  logic [IW-1:0]        m_ms_id;
  logic [AW-1:0]        m_ms_addr;
  logic [DW-1:0]        m_ms_data;
  logic                 m_sm_valid, m_sm_taken;
  logic [IW-1:0]        m_sm_id;
  logic [DW-1:0]        m_sm_data;
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
  logic                 id_error;
`endif

  memory_bus_arbiter #(
    .N_PORTS(N), .MASTER_ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sbus_ms_valid   (s_ms_valid),
    .sbus_ms_taken   (s_ms_taken),
    .sbus_ms_id      (s_ms_id),
    .sbus_ms_address (s_ms_addr),
    .sbus_ms_data    (s_ms_data),
    .sbus_sm_valid   (s_sm_valid),
    .sbus_sm_taken   (s_sm_taken),
    .sbus_sm_id      (s_sm_id),
    .sbus_sm_data    (s_sm_data),
    .mbus_ms_valid   (m_ms_valid),
    .mbus_ms_taken   (m_ms_taken),
    .mbus_ms_id      (m_ms_id),
    .mbus_ms_address (m_ms_addr),
    .mbus_ms_data    (m_ms_data),
    .mbus_sm_valid   (m_sm_valid),
    .mbus_sm_taken   (m_sm_taken),
    .mbus_sm_id      (m_sm_id),
    .mbus_sm_data    (m_sm_data)
`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
    ,
    .id_error        (id_error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  tk;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_exp_t;

  typedef struct {
    logic [N-1:0]  vld;
    logic          tk;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr);
    s_ms_valid[p] = 1'b1;
    s_ms_id[p]    = id;
    s_ms_addr[p]  = addr;
    s_ms_data[p]  = addr[DW-1:0] ^ 24'h5A5A5A;
  endtask

  // Expected downstream beat this cycle: fields of port p, msTaken on p if tk.
  task automatic push_req(input int p, input logic tk);
    req_exp_t e;
    e.tk   = tk ? N'(1 << p) : '0;
    e.id   = s_ms_id[p];
    e.addr = s_ms_addr[p];
    e.data = s_ms_data[p];
    req_q.push_back(e);
  endtask

  // Expected response beat this cycle: valid only on port p, mbus smTaken = tk.
  task automatic push_rsp(input int p, input logic tk);
    rsp_exp_t e;
    e.vld  = N'(1 << p);
    e.tk   = tk;
    e.id   = m_sm_id;
    e.data = m_sm_data;
    rsp_q.push_back(e);
  endtask

  // Monitor: compare every presented request/response beat against the queues.
  always @(negedge clk) begin
    req_exp_t r;
    rsp_exp_t q;
    if (rst_n) begin
      if (m_ms_valid) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_request: got id %0h, no beat expected (t=%0t)", m_ms_id, $time);
        end else begin
          r = req_q.pop_front();
          chk("req_taken", s_ms_taken, r.tk);
          chk("req_id",    m_ms_id,    r.id);
          chk("req_addr",  m_ms_addr,  r.addr);
          chk("req_data",  m_ms_data,  r.data);
        end
      end
      if (|s_sm_valid) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_response: got valid %b, no beat expected (t=%0t)", s_sm_valid, $time);
        end else begin
          q = rsp_q.pop_front();
          chk("rsp_valid", s_sm_valid, q.vld);
          chk("rsp_taken", m_sm_taken, q.tk);
          chk("rsp_id_bcast",   s_sm_id,   {N{q.id}});
          chk("rsp_data_bcast", s_sm_data, {N{q.data}});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    s_ms_valid = '1;
    s_ms_id    = '0;
    s_ms_addr  = '0;
    s_ms_data  = '0;
    s_sm_taken = '1;
    m_ms_taken = 1'b1;
    m_sm_valid = 1'b1;
    m_sm_id    = '0;
    m_sm_data  = '0;
    #3;
    // Reset forces every handshake output low despite active inputs.
    chk("rst_mbus_ms_valid", m_ms_valid, 0);
    chk("rst_sbus_ms_taken", s_ms_taken, 0);
    chk("rst_sbus_sm_valid", s_sm_valid, 0);
    chk("rst_mbus_sm_taken", m_sm_taken, 0);
    s_ms_valid = '0;
    m_sm_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

`ifdef MEMORY_BUS_ARBITER_ID_CHECK_EN
    // Duplicate outstanding ID stalls until the response handshake.
    set_port(1, 8'h07, 32'h7000_0001);
    push_req(1, 1'b1);
    cyc();
    s_ms_valid[1] = 1'b0;
    set_port(2, 8'h07, 32'h7000_0002);
    #1;
    chk("dup_id_stall_valid", m_ms_valid, 0);
    chk("dup_id_stall_taken", s_ms_taken, 0);
    cyc();
    chk("dup_id_stall_valid2", m_ms_valid, 0);
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h07;
    m_sm_data  = 24'h000707;
    push_rsp(1, 1'b1);
    #1;
    chk("dup_id_stall_on_rsp", m_ms_valid, 0);
    cyc();
    m_sm_valid = 1'b0;
    push_req(2, 1'b1);
    cyc();
    s_ms_valid[2] = 1'b0;
    chk("id_error_clear", id_error, 0);
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h33;
    m_sm_data  = 24'h003333;
    push_rsp(0, 1'b1);
    cyc();
    m_sm_valid = 1'b0;
    #1;
    chk("id_error_set", id_error, 1);
    cyc(); cyc();
    chk("id_error_sticky", id_error, 1);
`else
    // 1: all ports valid, always ready -> 0,1,2,3,0 on consecutive cycles.
    for (int i = 0; i < N; i++) set_port(i, 8'h40 + 8'(i), 32'h1000_0000 + 32'(i));
    m_ms_taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      push_req(c % N, 1'b1);
      cyc();
    end
    s_ms_valid = '0;

    // 2: lock on port 2 while stalled; port 1 joins but must wait (ptr=1 here).
    set_port(2, 8'h52, 32'h2000_0002);
    m_ms_taken = 1'b0;
    push_req(2, 1'b0);
    cyc();
    set_port(1, 8'h51, 32'h2000_0001);
    push_req(2, 1'b0);
    cyc();
    push_req(2, 1'b0);
    cyc();
    m_ms_taken = 1'b1;
    push_req(2, 1'b1);
    cyc();
    s_ms_valid[2] = 1'b0;
    push_req(1, 1'b1);
    cyc();
    s_ms_valid[1] = 1'b0;

    // 3: port 3 issues 0x15, port 0 issues 0x2A; responses return out of order (ptr=2).
    set_port(3, 8'h15, 32'h3000_0003);
    push_req(3, 1'b1);
    cyc();
    s_ms_valid[3] = 1'b0;
    set_port(0, 8'h2A, 32'h3000_0000);
    push_req(0, 1'b1);
    cyc();
    s_ms_valid[0] = 1'b0;
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h2A;
    m_sm_data  = 24'hABCD01;
    s_sm_taken = 4'b1110;
    push_rsp(0, 1'b0);
    cyc();
    push_rsp(0, 1'b0);
    cyc();
    s_sm_taken = 4'b1111;
    push_rsp(0, 1'b1);
    cyc();
    m_sm_id   = 8'h15;
    m_sm_data = 24'hABCD02;
    push_rsp(3, 1'b1);
    cyc();
    m_sm_valid = 1'b0;

    // 4: reset while locked on port 1 (ptr=1).
    set_port(1, 8'h61, 32'h4000_0001);
    m_ms_taken = 1'b0;
    push_req(1, 1'b0);
    cyc();
    set_port(0, 8'h60, 32'h4000_0000);
    push_req(1, 1'b0);
    cyc();
    rst_n      = 1'b0;
    m_ms_taken = 1'b1;
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h15;
    #1;
    chk("midrst_mbus_ms_valid", m_ms_valid, 0);
    chk("midrst_sbus_ms_taken", s_ms_taken, 0);
    chk("midrst_sbus_sm_valid", s_sm_valid, 0);
    chk("midrst_mbus_sm_taken", m_sm_taken, 0);
    m_sm_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    push_req(0, 1'b1);
    cyc();
    push_req(1, 1'b1);
    cyc();
    s_ms_valid = '0;
    // 0x15 belonged to port 3 before reset; the cleared table sends it to port 0.
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h15;
    m_sm_data  = 24'hABCD03;
    push_rsp(0, 1'b1);
    cyc();
    m_sm_valid = 1'b0;

    // 6: response on 0x10 in the same cycle port 3 re-issues 0x10 (ptr=2).
    set_port(0, 8'h10, 32'h6000_0000);
    push_req(0, 1'b1);
    cyc();
    s_ms_valid[0] = 1'b0;
    set_port(3, 8'h10, 32'h6000_0003);
    m_sm_valid = 1'b1;
    m_sm_id    = 8'h10;
    m_sm_data  = 24'hABCD10;
    push_req(3, 1'b1);
    push_rsp(0, 1'b1);
    cyc();
    s_ms_valid[3] = 1'b0;
    m_sm_data = 24'hABCD11;
    push_rsp(3, 1'b1);
    cyc();
    m_sm_valid = 1'b0;
`endif

    cyc(); cyc();
    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
